// File: rtl/bit_stream_pkg.sv
// bit_stream_pkg: shared types and sizing helpers for the bit-stream serializer.
//   state_t   : serializer FSM states (IDLE, SHIFT)
//   cnt_w     : bit-counter width for a given data width
//   frame_len : bits per frame, including the parity bit when enabled
//   Optional feature macro: BIT_STREAM_SERIALIZER_PARITY_EN (adds a trailing even-parity bit)
package bit_stream_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_len(input int width);
`ifdef BIT_STREAM_SERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/bit_stream_counter.sv
// bit_stream_counter: loadable down-counter with terminal-count flag.
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset (count returns to 0)
//   load_i     : load load_val_i this cycle (wins over en_i)
//   en_i       : decrement this cycle; holds at 0 once terminal count is reached
//   load_val_i : value to load
//   tc_o       : count is zero
//   Optional feature macro: BIT_STREAM_SERIALIZER_PARITY_EN (only affects load values chosen by the top)
module bit_stream_counter
    import bit_stream_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [CW-1:0] load_val_i,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = cnt_q == '0;

    always_comb cnt_d = load_i ? load_val_i : (en_i && !tc_o) ? cnt_q - CW'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;

endmodule

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: parallel word to 1-bit stream over a valid/ready handshake.
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   din       : parallel word, captured when din_valid && din_ready
//   din_valid : din holds a word
//   din_ready : word can be taken this cycle (idle, or last bit of the frame on x)
//   x         : serial bit, forced to 0 when x_valid is low
//   x_valid   : x carries a data (or parity) bit
//   busy      : a frame is in progress
//   Optional feature macro: BIT_STREAM_SERIALIZER_PARITY_EN (even-parity bit after the data bits)
module bit_stream_serializer
    import bit_stream_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CW        = cnt_w(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic             tc, accept, head;

    // Ready at the last bit lets the next word follow with no gap cycle.
    assign din_ready = !reset && (state_q == IDLE || tc);
    assign accept    = din_valid && din_ready;
    assign head      = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign x_valid   = state_q == SHIFT;
    assign busy      = x_valid;

    bit_stream_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .en_i       (state_q == SHIFT),
        .load_val_i (CW'(FRAME_LEN - 1)),
        .tc_o       (tc)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else if (accept) begin
            state_q <= SHIFT;
            sreg_q  <= din;
        end else if (state_q == SHIFT) begin
            state_q <= tc ? IDLE : SHIFT;
            sreg_q  <= MSB_FIRST ? sreg_q << 1 : sreg_q >> 1;
        end

`ifdef BIT_STREAM_SERIALIZER_PARITY_EN
    logic par_q;

    // The terminal-count cycle of a parity frame carries the parity bit.
    assign x = x_valid && (tc ? par_q : head);

    always_ff @(posedge clk or posedge reset)
        if (reset)       par_q <= 1'b0;
        else if (accept) par_q <= ^din;
`else
    assign x = x_valid && head;
`endif

endmodule
